sram_axi_bridge: RTL

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sram_axi_bridge.sv
// SRAM-like CPU data port to AXI bridge with a single outstanding transaction.
// Reads use AR/R, writes use AW/W/B, and each transaction finishes with a one-cycle data_data_ok.
module sram_axi_bridge #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        wstrb_r;
    logic              wr_r;
    logic              aw_done;
    logic              w_done;
    logic              accept;

    assign accept = data_req && (state == IDLE);

    always_comb begin
        state_nxt    = state;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (state)
            IDLE: begin
                data_addr_ok = 1'b1;
                if (data_req) state_nxt = data_wr ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) state_nxt = DONE;
            end
            WR_REQ: begin
                // AW and W complete independently; both must be done before waiting on B
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_nxt = DONE;
            end
            DONE: begin
                data_data_ok = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            addr_r     <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            wr_r       <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            data_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_r  <= data_addr;
                wdata_r <= data_wdata;
                wstrb_r <= data_wstrb;
                wr_r    <= data_wr;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == WR_REQ) begin
                if (awready) aw_done <= 1'b1;
                if (wready)  w_done  <= 1'b1;
            end
            if ((state == RD_DATA) && rvalid) data_rdata <= rdata;
        end
    end

    assign araddr = addr_r;
    assign awaddr = addr_r;
    assign wdata  = wdata_r;
    assign wstrb  = wstrb_r;

    logic unused_wr;
    assign unused_wr = wr_r;

endmodule
